// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern engine: FSM states, LFSR/MISR
// polynomials and the LFSR step function.
package bist_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_RUN, ST_CMP} state_t;

  localparam int          SIG_W     = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  // x^14+x^5+x^3+x+1: feedback from bits 13,4,2,0
  localparam logic [13:0] LFSR_TAPS = 14'h2015;

  function automatic logic [13:0] lfsr_step(logic [13:0] x);
    return {x[12:0], ^(x & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: folds the netlist response into a 16-bit
// signature. sig_nxt exposes the value being loaded so the top can compare early.
module bist_misr
  import bist_pkg::*;
#(
  parameter int PO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PO_W-1:0]  po_vec,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_nxt
);
  logic [SIG_W-1:0] step;

  always_comb begin
    step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(po_vec);
    if (clr)     sig_nxt = '0;
    else if (en) sig_nxt = step;
    else         sig_nxt = sig;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else     sig <= sig_nxt;
endmodule

// File: rtl/bist_pattern_engine.sv
// BIST engine: LFSR pattern source, pattern counter and run FSM; responses are
// compacted by bist_misr and checked against GOLDEN at the end of a run.
module bist_pattern_engine
  import bist_pkg::*;
#(
  parameter int          PI_W   = 14,
  parameter int          PO_W   = 8,
  parameter int          N_PAT  = 256,
  parameter logic [13:0] SEED   = 14'h0001,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [PI_W-1:0]  pi_vec,
  input  logic [PO_W-1:0]  po_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);
  // An all-zero seed would lock the LFSR up
  localparam logic [13:0] SEED_EFF = (SEED == 14'h0) ? 14'h0001 : SEED;
  localparam logic [15:0] CNT_LAST = 16'(N_PAT - 1);

  state_t           state_q, state_d;
  logic [13:0]      lfsr, lfsr_nxt;
  logic [15:0]      cnt;
  logic             misr_clr, misr_en;
  logic [SIG_W-1:0] sig_nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SEED;
      ST_SEED: state_d = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort)                 state_d = ST_IDLE;
        else if (cnt == CNT_LAST)  state_d = ST_CMP;
      end
      ST_CMP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_SEED) || (state_q == ST_RUN);
    done     = (state_q == ST_CMP);
    misr_clr = (state_q == ST_SEED) && !abort;
    misr_en  = (state_q == ST_RUN)  && !abort;
    lfsr_nxt = lfsr;
    if (misr_clr)     lfsr_nxt = SEED_EFF;
    else if (misr_en) lfsr_nxt = lfsr_step(lfsr);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr   <= SEED_EFF;
      cnt    <= '0;
      pi_vec <= '0;
      pass   <= 1'b0;
    end else begin
      lfsr   <= lfsr_nxt;
      // pi_vec tracks the LFSR only while running, so the netlist sees 0 when idle
      pi_vec <= (state_d == ST_RUN) ? PI_W'(lfsr_nxt) : '0;
      if (misr_clr)     cnt <= '0;
      else if (misr_en) cnt <= cnt + 16'd1;
      if ((state_q == ST_IDLE && start) || (busy && abort))
        pass <= 1'b0;
      else if (state_q == ST_RUN && state_d == ST_CMP)
        pass <= (sig_nxt == GOLDEN);
    end

  bist_misr #(.PO_W(PO_W)) u_misr (
    .clk     (clk),
    .rst     (rst),
    .clr     (misr_clr),
    .en      (misr_en),
    .po_vec  (po_vec),
    .sig     (signature),
    .sig_nxt (sig_nxt)
  );
endmodule

// File: tb/tb_bist_pattern_engine.sv
// Self-checking bench: three engine instances with different N_PAT/SEED, driven
// by a toy netlist function and checked against an arithmetic reference model.
module tb_bist_pattern_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance a: N_PAT=4, SEED=1
  logic start4, abort4, busy4, done4, pass4, mode4;
  logic [13:0] pi4;
  logic [7:0]  po4, key4, cpo4;
  logic [15:0] sig4;
  // instance b: N_PAT=2, SEED=1
  logic start2, abort2, busy2, done2, pass2;
  logic [13:0] pi2;
  logic [7:0]  po2;
  logic [15:0] sig2;
  // instance c: N_PAT=1000, SEED=0
  logic startz, abortz, busyz, donez, passz;
  logic [13:0] piz;
  logic [7:0]  poz, keyz;
  logic [15:0] sigz;

  function automatic logic [7:0] net(logic [13:0] pi, logic [7:0] key);
    return (pi[7:0] & pi[13:6]) ^ {pi[3:0], pi[13:10]} ^ key;
  endfunction

  assign po4 = mode4 ? net(pi4, key4) : cpo4;
  assign poz = net(piz, keyz);

  bist_pattern_engine #(.N_PAT(4), .SEED(14'h0001), .GOLDEN(16'h0000)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .pi_vec(pi4), .po_vec(po4),
    .busy(busy4), .done(done4), .pass(pass4), .signature(sig4));
  bist_pattern_engine #(.N_PAT(2), .SEED(14'h0001), .GOLDEN(16'h0000)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .pi_vec(pi2), .po_vec(po2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));
  bist_pattern_engine #(.N_PAT(1000), .SEED(14'h0000), .GOLDEN(16'h0000)) uz (
    .clk(clk), .rst(rst), .start(startz), .abort(abortz), .pi_vec(piz), .po_vec(poz),
    .busy(busyz), .done(donez), .pass(passz), .signature(sigz));

  // ---- reference model: polynomial arithmetic on integers ----
  function automatic int m_lfsr(int x);
    int fb;
    fb = ((x >> 13) ^ (x >> 4) ^ (x >> 2) ^ x) & 1;
    return ((x * 2) % 16384) + fb;
  endfunction

  function automatic int m_fold(int s, int po);
    int v;
    v = s * 2;
    if (v >= 65536) v = (v - 65536) ^ 'h1021;
    return v ^ po;
  endfunction

  // signature after n patterns from seed; mode 0 = constant response c
  function automatic int m_sig(int seed, int n, bit mode, logic [7:0] key, int c);
    int x, s, po;
    x = seed; s = 0;
    for (int i = 0; i < n; i++) begin
      po = mode ? int'(net(14'(x), key)) : c;
      s  = m_fold(s, po);
      x  = m_lfsr(x);
    end
    return s;
  endfunction

  // ---- capture of a run on instance a ----
  logic [13:0] cap [0:63];
  int ncap, done_at, ndone;
  logic [15:0] sig_at;
  logic pass_at;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run4(input int max_cyc);
    ncap = 0; done_at = -1; ndone = 0; sig_at = '0; pass_at = 1'b0;
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (done4) begin
        ndone++;
        if (done_at < 0) begin done_at = k; sig_at = sig4; pass_at = pass4; end
      end else if (busy4 && k >= 2 && done_at < 0 && ncap < 64) begin
        cap[ncap] = pi4; ncap++;
      end
      tick();
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst = 1'b1;
    start4 = 0; abort4 = 0; mode4 = 0; cpo4 = 0; key4 = 0;
    start2 = 0; abort2 = 0; po2 = 0;
    startz = 0; abortz = 0; keyz = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({pi4, busy4, done4, pass4, sig4} !== 33'h0) begin
      errors++; $display("FAIL reset_a: got pi=%h busy=%b done=%b pass=%b sig=%h, want all 0",
                         pi4, busy4, done4, pass4, sig4);
    end
    checks++;
    if ({piz, busyz, donez, passz, sigz} !== 33'h0) begin
      errors++; $display("FAIL reset_z: got pi=%h busy=%b sig=%h, want all 0", piz, busyz, sigz);
    end
  endtask

  task automatic test_pattern_seq();
    logic [13:0] exp_seq [0:3];
    exp_seq[0] = 14'h0001; exp_seq[1] = 14'h0003; exp_seq[2] = 14'h0007; exp_seq[3] = 14'h000E;
    mode4 = 0; cpo4 = 8'h00;
    run4(10);
    checks++;
    if (ncap !== 4) begin errors++; $display("FAIL seq_len: got %0d patterns, want 4", ncap); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i < ncap && cap[i] !== exp_seq[i]) begin
        errors++; $display("FAIL seq_pi[%0d]: got %h, want %h", i, cap[i], exp_seq[i]);
      end
    end
    checks++;
    if (done_at !== 6) begin errors++; $display("FAIL seq_done_cycle: got %0d, want 6", done_at); end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL seq_done_count: got %0d, want 1", ndone); end
    checks++;
    if (sig_at !== 16'h0000 || pass_at !== 1'b1) begin
      errors++; $display("FAIL seq_result: got sig=%h pass=%b, want 0000/1", sig_at, pass_at);
    end
    checks++;
    if (sig4 !== 16'h0000 || pass4 !== 1'b1 || pi4 !== 14'h0) begin
      errors++; $display("FAIL seq_hold: got sig=%h pass=%b pi=%h, want 0000/1/0", sig4, pass4, pi4);
    end
  endtask

  task automatic test_signature();
    int d_at;
    logic [15:0] s;
    logic p;
    d_at = -1; s = '0; p = 1'b1;
    po2 = 8'hFF;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (done2 && d_at < 0) begin d_at = k; s = sig2; p = pass2; end
      tick();
    end
    checks++;
    if (d_at !== 4) begin errors++; $display("FAIL sig_done_cycle: got %0d, want 4", d_at); end
    checks++;
    if (s !== 16'h0101 || p !== 1'b0) begin
      errors++; $display("FAIL sig_ff: got sig=%h pass=%b, want 0101/0", s, p);
    end
  endtask

  task automatic test_random();
    int x, es;
    for (int r = 0; r < 4; r++) begin
      mode4 = 1; key4 = 8'($urandom);
      run4(10);
      es = m_sig(1, 4, 1'b1, key4, 0);
      x = 1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap[i] !== 14'(x)) begin
          errors++; $display("FAIL rand_pi[%0d] key=%h: got %h, want %h", i, key4, cap[i], 14'(x));
        end
        x = m_lfsr(x);
      end
      checks++;
      if (done_at !== 6 || sig_at !== 16'(es) || pass_at !== (es == 0)) begin
        errors++; $display("FAIL rand_sig key=%h: got done@%0d sig=%h pass=%b, want 6/%h/%b",
                           key4, done_at, sig_at, pass_at, 16'(es), es == 0);
      end
    end
  endtask

  task automatic test_abort();
    int es, nd, x;
    mode4 = 1; key4 = 8'($urandom);
    es = m_sig(1, 2, 1'b1, key4, 0);
    nd = 0;
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      abort4 = (k == 4);
      if (done4) nd++;
      if (k == 5) begin
        checks++;
        if (busy4 !== 1'b0 || pi4 !== 14'h0 || pass4 !== 1'b0 || sig4 !== 16'(es)) begin
          errors++; $display("FAIL abort_state: got busy=%b pi=%h pass=%b sig=%h, want 0/0/0/%h",
                             busy4, pi4, pass4, sig4, 16'(es));
        end
      end
      tick();
    end
    abort4 = 1'b0;
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_done: got %0d dones, want 0", nd); end
    run4(10);
    x = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== 14'(x)) begin
        errors++; $display("FAIL abort_rerun_pi[%0d]: got %h, want %h", i, cap[i], 14'(x));
      end
      x = m_lfsr(x);
    end
    checks++;
    if (done_at !== 6 || sig_at !== 16'(m_sig(1, 4, 1'b1, key4, 0))) begin
      errors++; $display("FAIL abort_rerun_sig: got done@%0d sig=%h, want 6/%h",
                         done_at, sig_at, 16'(m_sig(1, 4, 1'b1, key4, 0)));
    end
  endtask

  task automatic test_back_to_back();
    int nd, busy_late;
    mode4 = 0; cpo4 = 8'($urandom);
    nd = 0; busy_late = 0;
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      start4 = (k >= 3 && k <= 6);
      if (done4) nd++;
      if (k >= 7 && busy4) busy_late++;
      tick();
    end
    start4 = 1'b0;
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL busy_start_done: got %0d dones, want 1", nd); end
    checks++;
    if (busy_late !== 0) begin
      errors++; $display("FAIL busy_start_restart: got %0d busy cycles after CMP, want 0", busy_late);
    end
  endtask

  task automatic test_async_reset();
    mode4 = 1; key4 = 8'($urandom);
    start4 = 1'b1; tick(); start4 = 1'b0;
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({pi4, busy4, done4, pass4, sig4} !== 33'h0) begin
      errors++; $display("FAIL async_rst_a: got pi=%h busy=%b done=%b pass=%b sig=%h, want all 0",
                         pi4, busy4, done4, pass4, sig4);
    end
    checks++;
    if (sig2 !== 16'h0) begin errors++; $display("FAIL async_rst_b: got sig=%h, want 0000", sig2); end
    tick();
    rst = 1'b0;
    tick();
    run4(10);
    checks++;
    if (done_at !== 6 || sig_at !== 16'(m_sig(1, 4, 1'b1, key4, 0))) begin
      errors++; $display("FAIL async_rst_rerun: got done@%0d sig=%h, want 6/%h",
                         done_at, sig_at, 16'(m_sig(1, 4, 1'b1, key4, 0)));
    end
  endtask

  task automatic test_seed_zero();
    int d_at, npat, nzero, es;
    logic [13:0] first;
    logic [15:0] s;
    d_at = -1; npat = 0; nzero = 0; first = '1; s = '0;
    keyz = 8'($urandom);
    es = m_sig(1, 1000, 1'b1, keyz, 0);
    startz = 1'b1; tick(); startz = 1'b0;
    for (int k = 1; k <= 1010; k++) begin
      if (donez && d_at < 0) begin d_at = k; s = sigz; end
      else if (busyz && k >= 2 && d_at < 0) begin
        if (npat == 0) first = piz;
        if (piz == 14'h0) nzero++;
        npat++;
      end
      tick();
    end
    checks++;
    if (first !== 14'h0001) begin errors++; $display("FAIL seed0_first: got %h, want 0001", first); end
    checks++;
    if (nzero !== 0 || npat !== 1000) begin
      errors++; $display("FAIL seed0_patterns: got %0d patterns, %0d zero; want 1000, 0", npat, nzero);
    end
    checks++;
    if (d_at !== 1002 || s !== 16'(es)) begin
      errors++; $display("FAIL seed0_sig: got done@%0d sig=%h, want 1002/%h", d_at, s, 16'(es));
    end
  endtask

  initial begin
    rst = 1'b1;
    #1;
    test_reset();
    test_pattern_seq();
    test_signature();
    test_random();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_seed_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bist_pattern_engine.md
# bist_pattern_engine

Self-test engine that sits on the opposite side of the generated combinational benchmark netlists: it drives their 14 primary inputs and consumes their 8 primary outputs. Per run it generates N pseudo-random input vectors, compacts the responses into a 16-bit signature, and compares that signature with a golden value. The optimisation flow uses it to confirm on silicon or in emulation that an optimized netlist still matches its original.

## Interface
Parameters:
- `PI_W`, 14: width of the input vector driven into the netlist.
- `PO_W`, 8: width of the response vector; must be ≤ 16.
- `N_PAT`, 256: patterns per run; range 1..65535.
- `SEED`, 14'h0001: LFSR load value. A value of 0 is replaced by 14'h0001.
- `GOLDEN`, 16'h0000: expected signature.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: starts a run; sampled only in IDLE.
- `abort`, in, 1: synchronous cancel of a run in progress.
- `pi_vec`, out, PI_W: registered input vector to the netlist.
- `po_vec`, in, PO_W: netlist response, combinational from `pi_vec`.
- `busy`, out, 1: high in SEED and RUN.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `pass`, out, 1: result of the last completed run; held until the next `start` or `abort`.
- `signature`, out, 16: MISR contents; held after a run.

## Operation
States (FSM):
- **IDLE**
  - `start`=1 → SEED.
- **SEED**, 1 cycle
  - Load `lfsr`=SEED, `misr`=0, `cnt`=0.
  - Clear `pass`.
  - → RUN.
- **RUN**
  - `pi_vec` = `lfsr`.
  - At each edge, fold `po_vec` into the MISR, advance the LFSR and increment `cnt`.
  - When `cnt`=N_PAT-1 at the edge → CMP.
- **CMP**, 1 cycle
  - `done`=1.
  - `pass` ← (`misr`==GOLDEN).
  - → IDLE.

LFSR step, polynomial x^14+x^5+x^3+x+1:
- `lfsr_next` = {lfsr[12:0], lfsr[13]^lfsr[4]^lfsr[2]^lfsr[0]}.

MISR step, polynomial x^16+x^12+x^5+1:
- `misr_next` = ({misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0)) ^ zero-extended `po_vec`.

Other rules:
- `cnt` is 16 bits.
- `start` is ignored outside IDLE and causes no restart.
- `abort` in SEED/RUN → IDLE next edge; `busy`=0, no `done`, `pass`=0, `signature` frozen. `abort` takes priority over the RUN→CMP transition.
- `pi_vec` returns to 0 in IDLE.

## Timing
- Reset values: `pi_vec`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0, state IDLE, `lfsr`=SEED.
- Run timeline, with `start` sampled at edge t0:
  - SEED during cycle t0+1.
  - RUN during cycles t0+2 .. t0+N_PAT+1; pattern i is on `pi_vec` during cycle t0+2+i.
  - `done` high during cycle t0+N_PAT+2.
  - `pass` and `signature` valid from that same cycle.
- `start` held high in CMP is ignored. `start` asserted in the first IDLE cycle after CMP begins a new run.
- `rst` asserted mid-run returns every output to its reset value immediately, independent of the clock.
- `po_vec` is assumed to settle within one cycle; there is no response pipeline stage.

## Structure
- Package `bist_pkg`:
  - state enum {IDLE, SEED, RUN, CMP}
  - `LFSR_TAPS`, `MISR_POLY`=16'h1021
  - `SIG_W`=16
- Sub-module `bist_misr` (parameter `PO_W`): inputs `clr` and `en`, output `sig`. The LFSR, counter and FSM live in the top module.

## Test plan
- **Pattern sequence:** N_PAT=4, SEED=1, `po_vec` tied to 0 → `pi_vec` sequence 0x0001, 0x0003, 0x0007, 0x000E; `signature`=0x0000; with GOLDEN=0, `pass`=1 and `done` exactly 6 cycles after the `start` edge.
- **Signature arithmetic:** N_PAT=2, `po_vec`=8'hFF constant → `signature`=0x0101; GOLDEN=0 → `pass`=0.
- **Abort:** `abort` during RUN, third pattern → `busy` low next cycle, no `done`, `pass`=0, `pi_vec`=0; a following `start` reruns from SEED with an identical `pi_vec` sequence.
- **Busy start:** `start` pulsed during RUN and held through CMP → single `done`; no second run begins until `start` is seen in IDLE.
- **Async reset:** `rst` asserted mid-RUN between clock edges → all outputs 0 before the next edge; normal run afterwards.
- **Seed of zero:** SEED=0 → first pattern is 0x0001; the LFSR never reaches the all-zero state over 1000 patterns.
